// File: rtl/block_slider.sv
// block_slider
// Moving block for the current level of the stacker game. After a launch the
// block slides one cell at a time and bounces off the screen edges. When the
// player presses stop, the block is trimmed to its overlap with the block
// placed on the previous level. The result is then presented for one cycle.
//
// Ports:
//   clk, reset          - system clock; asynchronous active-high reset
//   start_level         - pulse that launches a new block (honoured in IDLE)
//   stop_btn            - pulse that freezes the block (honoured in MOVE)
//   first_level         - no previous block exists; the stop always intersects
//   prev_block_start/end/size - previously placed block (pixels / cells)
//   curr_block_start/end/size - moving or trimmed block (pixels / cells)
//   stop_true           - one-cycle pulse; curr_* are final during it
//   intersect_true      - overlap result, held until the next launch
//   moving              - block is sliding
//   game_over           - sticky miss indicator, cleared only by reset
module block_slider #(
    parameter int SCREEN_W  = 320,
    parameter int CELL_W    = 8,
    parameter int TICK_DIV  = 500000,
    parameter int INIT_SIZE = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_level,
    input  logic       stop_btn,
    input  logic       first_level,
    input  logic [8:0] prev_block_start,
    input  logic [8:0] prev_block_end,
    input  logic [3:0] prev_block_size,
    output logic [8:0] curr_block_start,
    output logic [8:0] curr_block_end,
    output logic [3:0] curr_block_size,
    output logic       stop_true,
    output logic       intersect_true,
    output logic       moving,
    output logic       game_over
);

    localparam int              CELL_SHIFT  = $clog2(CELL_W);
    localparam int              TICK_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [9:0]      CELL_STEP   = 10'(CELL_W);
    localparam logic [9:0]      LAST_COL    = 10'(SCREEN_W - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [3:0]      INIT_SIZE_C = 4'(INIT_SIZE);

    typedef enum logic [2:0] {IDLE, MOVE, EVAL, DONE, OVER} state_t;

    state_t            state;
    state_t            state_next;
    logic              dir_left;
    logic [TICK_W-1:0] tick_cnt;

    // Positions are widened to 10 bits so edge tests never wrap at 511.
    logic [9:0] start_w;
    logic [9:0] end_w;
    logic [9:0] prev_start_w;
    logic [9:0] prev_end_w;
    logic [3:0] launch_size;
    logic [9:0] launch_end;
    logic       can_right;
    logic       can_left;
    logic       tick_last;
    logic [9:0] step_start;
    logic [9:0] step_end;
    logic       step_dir_left;
    logic [9:0] ov_s;
    logic [9:0] ov_e;
    logic [9:0] ov_len;
    logic       ov_hit;
    logic [3:0] ov_size;

    assign start_w      = {1'b0, curr_block_start};
    assign end_w        = {1'b0, curr_block_end};
    assign prev_start_w = {1'b0, prev_block_start};
    assign prev_end_w   = {1'b0, prev_block_end};
    assign launch_size  = first_level ? INIT_SIZE_C : prev_block_size;
    assign launch_end   = ({6'd0, launch_size} << CELL_SHIFT) - 10'd1;
    assign can_right    = (end_w + CELL_STEP) <= LAST_COL;
    assign can_left     = start_w >= CELL_STEP;
    assign tick_last    = tick_cnt == TICK_LAST;
    assign moving       = state == MOVE;

    // Overlap with the placed block; widths are whole cells because every
    // position is a multiple of CELL_W, so a plain shift gives the size.
    assign ov_s    = (start_w >= prev_start_w) ? start_w : prev_start_w;
    assign ov_e    = (end_w <= prev_end_w) ? end_w : prev_end_w;
    assign ov_hit  = ov_s <= ov_e;
    assign ov_len  = ov_e - ov_s + 10'd1;
    assign ov_size = 4'(ov_len >> CELL_SHIFT);

    // One movement step. When the way ahead is blocked the direction flips and
    // the step goes the other way; a full-width block can go neither way, so
    // only its direction toggles.
    always_comb begin
        step_start    = start_w;
        step_end      = end_w;
        step_dir_left = dir_left;
        if (!dir_left) begin
            if (can_right) begin
                step_start = start_w + CELL_STEP;
                step_end   = end_w + CELL_STEP;
            end else begin
                step_dir_left = 1'b1;
                if (can_left) begin
                    step_start = start_w - CELL_STEP;
                    step_end   = end_w - CELL_STEP;
                end
            end
        end else begin
            if (can_left) begin
                step_start = start_w - CELL_STEP;
                step_end   = end_w - CELL_STEP;
            end else begin
                step_dir_left = 1'b0;
                if (can_right) begin
                    step_start = start_w + CELL_STEP;
                    step_end   = end_w + CELL_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE looks at intersect_true, which already holds the EVAL result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_level) state_next = (launch_size == 4'd0) ? OVER : MOVE;
            MOVE: if (stop_btn) state_next = EVAL;
            EVAL: state_next = DONE;
            DONE: state_next = intersect_true ? IDLE : OVER;
            OVER: state_next = OVER;
            default: state_next = IDLE;
        endcase
    end

    // Block position, tick counter and result registers. Stop takes priority
    // over a coinciding tick so the block freezes where the player saw it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curr_block_start <= '0;
            curr_block_end   <= '0;
            curr_block_size  <= '0;
            stop_true        <= 1'b0;
            intersect_true   <= 1'b0;
            game_over        <= 1'b0;
            dir_left         <= 1'b0;
            tick_cnt         <= '0;
        end else begin
            stop_true <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_level) begin
                        curr_block_size  <= launch_size;
                        curr_block_start <= '0;
                        curr_block_end   <= 9'(launch_end);
                        dir_left         <= 1'b0;
                        tick_cnt         <= '0;
                        intersect_true   <= 1'b0;
                        if (launch_size == 4'd0) game_over <= 1'b1;
                    end
                end
                MOVE: begin
                    if (!stop_btn) begin
                        if (tick_last) begin
                            tick_cnt         <= '0;
                            curr_block_start <= 9'(step_start);
                            curr_block_end   <= 9'(step_end);
                            dir_left         <= step_dir_left;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                EVAL: begin
                    stop_true <= 1'b1;
                    if (first_level) begin
                        intersect_true <= 1'b1;
                    end else if (ov_hit) begin
                        curr_block_start <= 9'(ov_s);
                        curr_block_end   <= 9'(ov_e);
                        curr_block_size  <= ov_size;
                        intersect_true   <= 1'b1;
                    end else begin
                        curr_block_size <= '0;
                        intersect_true  <= 1'b0;
                    end
                end
                DONE: begin
                    if (!intersect_true) game_over <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_slider.sv
// tb_block_slider
// Directed bench for block_slider with SCREEN_W=64, CELL_W=8, TICK_DIV=4,
// INIT_SIZE=3. Inputs change on the falling edge; outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
module tb_block_slider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_level;
    logic       stop_btn;
    logic       first_level;
    logic [8:0] prev_block_start;
    logic [8:0] prev_block_end;
    logic [3:0] prev_block_size;
    logic [8:0] curr_block_start;
    logic [8:0] curr_block_end;
    logic [3:0] curr_block_size;
    logic       stop_true;
    logic       intersect_true;
    logic       moving;
    logic       game_over;

    int errors = 0;
    int checks = 0;

    block_slider #(
        .SCREEN_W (64),
        .CELL_W   (8),
        .TICK_DIV (4),
        .INIT_SIZE(3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_level     (start_level),
        .stop_btn        (stop_btn),
        .first_level     (first_level),
        .prev_block_start(prev_block_start),
        .prev_block_end  (prev_block_end),
        .prev_block_size (prev_block_size),
        .curr_block_start(curr_block_start),
        .curr_block_end  (curr_block_end),
        .curr_block_size (curr_block_size),
        .stop_true       (stop_true),
        .intersect_true  (intersect_true),
        .moving          (moving),
        .game_over       (game_over)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge after the launch edge.
    task automatic pulse_start();
        start_level = 1'b1;
        @(negedge clk);
        start_level = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_btn = 1'b1;
        @(negedge clk);
        stop_btn = 1'b0;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        start_level      = 1'b0;
        stop_btn         = 1'b0;
        first_level      = 1'b1;
        prev_block_start = '0;
        prev_block_end   = '0;
        prev_block_size  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({curr_block_start, curr_block_end, curr_block_size, stop_true, intersect_true, moving, game_over} !== 26'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got start=%0d end=%0d size=%0d st=%b it=%b mv=%b go=%b expected all 0",
                     curr_block_start, curr_block_end, curr_block_size, stop_true, intersect_true, moving, game_over);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({moving, game_over, stop_true} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got mv=%b go=%b st=%b expected 000", moving, game_over, stop_true);
        end
    endtask

    task automatic test_launch();
        first_level = 1'b1;
        pulse_start();
        checks++;
        if ({curr_block_start, curr_block_end, curr_block_size, moving} !== {9'd0, 9'd23, 4'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL launch: got %0d..%0d/%0d mv=%b expected 0..23/3 mv=1",
                     curr_block_start, curr_block_end, curr_block_size, moving);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (curr_block_start !== 9'd0) begin
            errors++;
            $display("[TB] FAIL no_early_step: got start=%0d expected 0", curr_block_start);
        end
        @(negedge clk);
        checks++;
        if ({curr_block_start, curr_block_end} !== {9'd8, 9'd31}) begin
            errors++;
            $display("[TB] FAIL first_step: got %0d..%0d expected 8..31", curr_block_start, curr_block_end);
        end
    endtask

    task automatic test_bounce();
        logic [8:0] exp_start [10];
        exp_start = '{9'd16, 9'd24, 9'd32, 9'd40, 9'd32, 9'd24, 9'd16, 9'd8, 9'd0, 9'd8};
        for (int i = 0; i < 10; i++) begin
            repeat (4) @(negedge clk);
            checks++;
            if ({curr_block_start, curr_block_end, curr_block_size, moving} !==
                {exp_start[i], exp_start[i] + 9'd23, 4'd3, 1'b1}) begin
                errors++;
                $display("[TB] FAIL bounce_%0d: got %0d..%0d/%0d mv=%b expected %0d..%0d/3 mv=1", i,
                         curr_block_start, curr_block_end, curr_block_size, moving, exp_start[i], exp_start[i] + 9'd23);
            end
        end
    endtask

    task automatic test_partial_overlap();
        first_level      = 1'b0;
        prev_block_start = 9'd16;
        prev_block_end   = 9'd39;
        prev_block_size  = 4'd3;
        repeat (8) @(negedge clk);
        checks++;
        if ({curr_block_start, curr_block_end} !== {9'd24, 9'd47}) begin
            errors++;
            $display("[TB] FAIL overlap_prestop: got %0d..%0d expected 24..47", curr_block_start, curr_block_end);
        end
        pulse_stop();
        checks++;
        if ({stop_true, moving} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL overlap_eval: got st=%b mv=%b expected 00", stop_true, moving);
        end
        @(negedge clk);
        checks++;
        if ({stop_true, intersect_true, curr_block_start, curr_block_end, curr_block_size} !==
            {1'b1, 1'b1, 9'd24, 9'd39, 4'd2}) begin
            errors++;
            $display("[TB] FAIL overlap_done: got st=%b it=%b %0d..%0d/%0d expected st=1 it=1 24..39/2",
                     stop_true, intersect_true, curr_block_start, curr_block_end, curr_block_size);
        end
        @(negedge clk);
        checks++;
        if ({stop_true, intersect_true, moving, game_over, curr_block_start, curr_block_end} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 9'd24, 9'd39}) begin
            errors++;
            $display("[TB] FAIL overlap_after: got st=%b it=%b mv=%b go=%b %0d..%0d expected st=0 it=1 mv=0 go=0 24..39",
                     stop_true, intersect_true, moving, game_over, curr_block_start, curr_block_end);
        end
    endtask

    task automatic test_stop_on_tick();
        first_level      = 1'b0;
        prev_block_start = 9'd0;
        prev_block_end   = 9'd15;
        prev_block_size  = 4'd2;
        pulse_start();
        checks++;
        if ({curr_block_start, curr_block_end, curr_block_size, moving, intersect_true} !==
            {9'd0, 9'd15, 4'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL tick_launch: got %0d..%0d/%0d mv=%b it=%b expected 0..15/2 mv=1 it=0",
                     curr_block_start, curr_block_end, curr_block_size, moving, intersect_true);
        end
        repeat (3) @(negedge clk);
        pulse_stop();
        checks++;
        if ({curr_block_start, curr_block_end, moving} !== {9'd0, 9'd15, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stop_on_tick: got %0d..%0d mv=%b expected 0..15 mv=0",
                     curr_block_start, curr_block_end, moving);
        end
        @(negedge clk);
        checks++;
        if ({stop_true, intersect_true, curr_block_start, curr_block_end, curr_block_size} !==
            {1'b1, 1'b1, 9'd0, 9'd15, 4'd2}) begin
            errors++;
            $display("[TB] FAIL tick_done: got st=%b it=%b %0d..%0d/%0d expected st=1 it=1 0..15/2",
                     stop_true, intersect_true, curr_block_start, curr_block_end, curr_block_size);
        end
        @(negedge clk);
        checks++;
        if ({stop_true, moving, game_over} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL tick_after: got st=%b mv=%b go=%b expected 000", stop_true, moving, game_over);
        end
    endtask

    task automatic test_miss();
        first_level      = 1'b0;
        prev_block_start = 9'd0;
        prev_block_end   = 9'd7;
        prev_block_size  = 4'd1;
        pulse_start();
        checks++;
        if ({curr_block_start, curr_block_end, curr_block_size} !== {9'd0, 9'd7, 4'd1}) begin
            errors++;
            $display("[TB] FAIL miss_launch: got %0d..%0d/%0d expected 0..7/1",
                     curr_block_start, curr_block_end, curr_block_size);
        end
        repeat (20) @(negedge clk);
        checks++;
        if ({curr_block_start, curr_block_end} !== {9'd40, 9'd47}) begin
            errors++;
            $display("[TB] FAIL miss_prestop: got %0d..%0d expected 40..47", curr_block_start, curr_block_end);
        end
        pulse_stop();
        @(negedge clk);
        checks++;
        if ({stop_true, intersect_true, curr_block_size, curr_block_start, curr_block_end, game_over} !==
            {1'b1, 1'b0, 4'd0, 9'd40, 9'd47, 1'b0}) begin
            errors++;
            $display("[TB] FAIL miss_done: got st=%b it=%b size=%0d %0d..%0d go=%b expected st=1 it=0 size=0 40..47 go=0",
                     stop_true, intersect_true, curr_block_size, curr_block_start, curr_block_end, game_over);
        end
        @(negedge clk);
        checks++;
        if ({stop_true, game_over} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL miss_game_over: got st=%b go=%b expected st=0 go=1", stop_true, game_over);
        end
        pulse_start();
        pulse_stop();
        @(negedge clk);
        checks++;
        if ({moving, game_over, stop_true, curr_block_start, curr_block_size} !==
            {1'b0, 1'b1, 1'b0, 9'd40, 4'd0}) begin
            errors++;
            $display("[TB] FAIL over_ignores: got mv=%b go=%b st=%b start=%0d size=%0d expected mv=0 go=1 st=0 start=40 size=0",
                     moving, game_over, stop_true, curr_block_start, curr_block_size);
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        first_level = 1'b1;
        pulse_start();
        repeat (5) @(negedge clk);
        checks++;
        if ({curr_block_start, moving} !== {9'd8, 1'b1}) begin
            errors++;
            $display("[TB] FAIL pre_mid_reset: got start=%0d mv=%b expected start=8 mv=1", curr_block_start, moving);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({curr_block_start, curr_block_end, curr_block_size, stop_true, intersect_true, moving, game_over} !== 26'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got start=%0d end=%0d size=%0d st=%b it=%b mv=%b go=%b expected all 0",
                     curr_block_start, curr_block_end, curr_block_size, stop_true, intersect_true, moving, game_over);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({moving, curr_block_start} !== {1'b0, 9'd0}) begin
            errors++;
            $display("[TB] FAIL no_relaunch: got mv=%b start=%0d expected mv=0 start=0", moving, curr_block_start);
        end
    endtask

    task automatic test_zero_size();
        first_level     = 1'b0;
        prev_block_size = 4'd0;
        pulse_start();
        checks++;
        if ({game_over, moving, stop_true, curr_block_size, curr_block_start} !==
            {1'b1, 1'b0, 1'b0, 4'd0, 9'd0}) begin
            errors++;
            $display("[TB] FAIL zero_size: got go=%b mv=%b st=%b size=%0d start=%0d expected go=1 mv=0 st=0 size=0 start=0",
                     game_over, moving, stop_true, curr_block_size, curr_block_start);
        end
        repeat (8) @(negedge clk);
        checks++;
        if ({game_over, moving} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL zero_size_hold: got go=%b mv=%b expected go=1 mv=0", game_over, moving);
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_bounce();
        test_partial_overlap();
        test_stop_on_tick();
        test_miss();
        test_mid_reset();
        test_zero_size();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_slider.md
# block_slider

Drives the moving block for the current level of the stacker game: it slides the block horizontally in whole cells, bouncing off the screen edges, until the player presses stop. On stop it trims the block to its overlap with the previously placed block. It then presents the trimmed block with a one-cycle `stop_true` pulse and `intersect_true`. It sits directly upstream of the placed-block tracker, which latches these outputs as the new previous block and feeds them back here.

## Interface
- `SCREEN_W`, 320: playfield width in pixels; legal columns are 0..SCREEN_W-1, and SCREEN_W ≤ 512.
- `CELL_W`, 8: cell width in pixels. Must be a power of two. It is also the step size.
- `TICK_DIV`, 500000: clock cycles per movement step, ≥ 2.
- `INIT_SIZE`, 6: block size in cells on the first level, 1..15, with INIT_SIZE*CELL_W ≤ SCREEN_W.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start_level` in 1: one-cycle pulse that launches a new moving block. Honoured only in IDLE.
- `stop_btn` in 1: one-cycle pulse that stops the block. Honoured only in MOVE.
- `first_level` in 1: 1 means there is no previous block, so the stopped block always intersects.
- `prev_block_start` in 9: leftmost pixel of the placed block.
- `prev_block_end` in 9: rightmost pixel of the placed block.
- `prev_block_size` in 4: placed block size in cells.
- `curr_block_start` out 9: leftmost pixel of the moving or trimmed block.
- `curr_block_end` out 9: rightmost pixel of the moving or trimmed block.
- `curr_block_size` out 4: moving or trimmed block size in cells.
- `stop_true` out 1: one-cycle pulse; curr_* are final during this cycle.
- `intersect_true` out 1: overlap result, valid while `stop_true` is high and held until the next launch.
- `moving` out 1: high in MOVE.
- `game_over` out 1: sticky miss indicator, cleared only by `reset`.

## Operation
- Reset values:
  - all outputs 0;
  - state IDLE; direction right; tick counter 0.
- States: IDLE, MOVE, EVAL, DONE, OVER.
- IDLE, on `start_level`:
  - size = INIT_SIZE if `first_level`, else `prev_block_size`;
  - start = 0; end = size*CELL_W-1; direction right; tick counter 0; `intersect_true` cleared.
  - If the size is 0, go to OVER with `game_over`=1. Otherwise go to MOVE.
- MOVE, tick counter:
  - counts 0..TICK_DIV-1 and wraps.
  - At TICK_DIV-1 the block takes one step of CELL_W pixels.
- MOVE, step direction:
  - Moving right: if end+CELL_W ≤ SCREEN_W-1, shift right. Otherwise flip to left and shift left.
  - Moving left: if start ≥ CELL_W, shift left. Otherwise flip to right and shift right.
  - A block exactly SCREEN_W wide never moves; only the direction toggles.
- MOVE, stop: `stop_btn` moves to EVAL. The position freezes, and a tick in the same cycle is ignored.
- EVAL, one cycle, compares using registered values:
  - ov_s = max(start, prev_block_start); ov_e = min(end, prev_block_end).
  - If `first_level`: the block is unchanged and intersect = 1.
  - Else if ov_s ≤ ov_e: start = ov_s; end = ov_e; size = (ov_e-ov_s+1) >> log2(CELL_W); intersect = 1.
  - Else: intersect = 0 and size = 0. start and end keep the stopped position.
- DONE, one cycle:
  - `stop_true`=1 and `intersect_true`=result.
  - Next state is IDLE if intersect = 1. Otherwise go to OVER and set `game_over`.
- OVER: all inputs are ignored and outputs are held until `reset`.
- Width rules:
  - Positions are always multiples of CELL_W, so overlaps are whole cells.
  - All arithmetic is 10-bit internally, with no 9-bit wrap.
- Inputs:
  - `stop_btn` outside MOVE is ignored.
  - `start_level` outside IDLE is ignored.
  - `prev_*` must be stable from EVAL through DONE.

## Timing
- Launch: `start_level` sampled at edge N gives curr_* valid and `moving`=1 after edge N.
- Movement: the first step lands TICK_DIV cycles after entry to MOVE, then one step every TICK_DIV cycles.
- Stop: `stop_btn` sampled at edge N.
  - EVAL occupies cycle N..N+1.
  - `stop_true`, `intersect_true` and the trimmed curr_* all go high or valid together after edge N+1, for exactly one cycle.
- The downstream tracker latches on `stop_true && intersect_true`. curr_* hold their values after DONE.
- Reset asserted mid-operation (any state) immediately forces the reset values. The next launch requires a fresh `start_level`.

## Test plan
Common bench parameters: SCREEN_W=64, CELL_W=8, TICK_DIV=4, INIT_SIZE=3.

1. **Reset and launch:** reset, then `start_level` with `first_level`=1 → start=0, end=23, size=3, `moving`=1. After 4 cycles start=8, end=31.
2. **Bounce:** let the block run → start sequence 0,8,16,24,32,40,32,…,0,8, with end never above 63 and start never below 0.
3. **Partial overlap:** prev=16..39/3, `first_level`=0, stop at 24..47 → two edges later `stop_true` pulses for one cycle with 24..39, size 2, `intersect_true`=1. Then IDLE.
4. **Miss:** prev=0..7/1, stop at 40..47 → `stop_true` with `intersect_true`=0, size 0, `game_over`=1. A later `start_level` is ignored.
5. **Collisions and mid-reset:**
   - `stop_btn` on a tick cycle → position is not advanced.
   - `reset` during MOVE → all outputs 0 immediately.
6. **Zero size:** `start_level` with `first_level`=0 and `prev_block_size`=0 → OVER, `game_over`=1, `moving` stays 0.
